// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the load/store memory responder.
//   mem_state_e    - responder FSM states (idle, wait states, response pending)
//   WordW / BeW    - data word width and byte-enable width
//   wait_cycles_ok - legality check for the WAIT_CYCLES parameter (0..15)
package riscv_mem_pkg;

   localparam int unsigned WordW         = 32;
   localparam int unsigned BeW           = 4;
   localparam int unsigned MaxWaitCycles = 15;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } mem_state_e;

   function automatic bit wait_cycles_ok(input int wc);
      return (wc >= 0) && (wc <= int'(MaxWaitCycles));
   endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// riscv_mem_array: single-port DEPTH_WORDS x 32 RAM, synchronous write and read.
//   clk   - clock
//   en    - port access this cycle
//   we    - 1 = write selected bytes, 0 = read full word into rdata
//   be    - per-byte write enables (bit i covers wdata[8i+7:8i])
//   idx   - word index
//   wdata - write data
//   rdata - read data, updated only by a read access and held otherwise
// Contents are not reset.
module riscv_mem_array
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [BeW-1:0]   be,
   input  logic [IDX_W-1:0] idx,
   input  logic [WordW-1:0] wdata,
   output logic [WordW-1:0] rdata
);

   logic [WordW-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < int'(BeW); i++) begin
               if (be[i]) begin
                  mem[idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/riscv_mem_resp.sv
// riscv_mem_resp: single-outstanding memory responder for the core's load/store port.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   req_valid/req_ready         - request handshake (accepted in idle)
//   req_we, req_addr            - store/load select, byte address
//   req_wdata, req_be           - store data and byte enables (ignored for loads)
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata, rsp_err          - load data (0 for stores/errors), error flag
// The RAM is accessed on the acceptance edge; the response appears WAIT_CYCLES edges later.
module riscv_mem_resp
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WordW-1:0]  req_wdata,
   input  logic [BeW-1:0]    req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WordW-1:0]  rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

   if (!wait_cycles_ok(int'(WAIT_CYCLES))) begin : gen_bad_wait_cycles
      $error("riscv_mem_resp: WAIT_CYCLES must be in 0..15");
   end

   mem_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             load_q, load_d;
   logic             accept;
   logic             addr_err;
   logic [ADDR_W-3:0] word_addr;
   logic [WordW-1:0] ram_rdata;

   assign word_addr = req_addr[ADDR_W-1:2];
   assign addr_err  = (req_addr[1:0] != 2'b00) || (32'(word_addr) >= 32'(DEPTH_WORDS));
   assign accept    = (state_q == StIdle) && req_valid;

   // Erroring requests never touch the RAM.
   riscv_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IdxW)
   ) u_array (
      .clk   (clk),
      .en    (accept && !addr_err),
      .we    (req_we),
      .be    (req_be),
      .idx   (word_addr[IdxW-1:0]),
      .wdata (req_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load_d  = load_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
               cnt_d   = WaitLoad;
               err_d   = addr_err;
               load_d  = !req_we && !addr_err;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         load_q  <= load_d;
      end
   end

   // The RAM read register holds the word read at acceptance; load_q gates it so stores,
   // errors and reset present zero data.
   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_err   = err_q;
   assign rsp_rdata = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_riscv_mem_resp.sv
module tb_riscv_mem_resp;

   localparam int NINST = 4;

   function automatic int wc_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 15;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_ready = 1'b1;
   int          sel = 0;

   logic [NINST-1:0] rq_w, rv_w, er_w;
   logic [31:0]      rd_w [NINST];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NINST; g++) begin : g_dut
      riscv_mem_resp #(
         .ADDR_W      (16),
         .DEPTH_WORDS (1024),
         .WAIT_CYCLES (wc_of(g))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid && (sel == g)),
         .req_ready (rq_w[g]),
         .req_we    (req_we),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .req_be    (req_be),
         .rsp_valid (rv_w[g]),
         .rsp_ready ((sel == g) ? rsp_ready : 1'b1),
         .rsp_rdata (rd_w[g]),
         .rsp_err   (er_w[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (inst %0d, t=%0t)",
                  name, got, exp, sel, $time);
      end
   endtask

   // Behavioural model: one outstanding transaction, response visible once WAIT_CYCLES
   // edges have passed since acceptance; memory is a sparse map keyed by instance and word.
   logic [31:0] mem_m [int];
   bit          m_busy = 0;
   int          m_age = 0;
   logic [31:0] m_rdata = '0;
   bit          m_err = 0;

   always @(posedge clk or negedge rst_n) begin : model
      int word;
      int key;
      logic [31:0] w;
      if (!rst_n) begin
         m_busy = 0;
         m_age  = 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            word    = int'(req_addr) / 4;
            m_err   = (req_addr % 4 != 0) || (word >= 1024);
            m_rdata = 0;
            key     = sel * 65536 + word;
            if (!m_err) begin
               if (req_we) begin
                  w = mem_m.exists(key) ? mem_m[key] : 32'h0;
                  for (int b = 0; b < 4; b++) begin
                     if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                  end
                  mem_m[key] = w;
               end else begin
                  m_rdata = mem_m.exists(key) ? mem_m[key] : 32'h0;
               end
            end
            m_busy = 1;
            m_age  = 0;
         end
      end else begin
         if (m_age >= wc_of(sel) && rsp_ready) m_busy = 0;
         else if (m_age < 1000) m_age++;
      end
   end

   always @(negedge clk) begin : compare
      bit exp_valid;
      exp_valid = m_busy && (m_age >= wc_of(sel));
      chk("cmp_req_ready", 32'(rq_w[sel]), 32'(!m_busy));
      chk("cmp_rsp_valid", 32'(rv_w[sel]), 32'(exp_valid));
      if (exp_valid) begin
         chk("cmp_rsp_rdata", rd_w[sel], m_rdata);
         chk("cmp_rsp_err", 32'(er_w[sel]), 32'(m_err));
      end
      if (!rst_n) begin
         chk("cmp_reset_rdata", rd_w[sel], 32'h0);
         chk("cmp_reset_err", 32'(er_w[sel]), 32'h0);
      end
   end

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic txn(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er);
      int n;
      int lat;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      rsp_ready = (hold == 0);
      n = 0;
      while (!rq_w[sel] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_timeout", 32'(rq_w[sel]), 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      lat = 0;
      while (!rv_w[sel] && lat < 40) begin
         chk("ready_low_in_wait", 32'(rq_w[sel]), 32'h0);
         @(posedge clk); #1;
         lat++;
      end
      chk("rsp_valid_timeout", 32'(rv_w[sel]), 32'h1);
      chk("latency", 32'(lat), 32'(wc_of(sel)));
      chk("ready_low_in_resp", 32'(rq_w[sel]), 32'h0);
      rd = rd_w[sel];
      er = er_w[sel];
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rv_w[sel]), 32'h1);
         chk("hold_rdata", rd_w[sel], rd);
         chk("hold_err", 32'(er_w[sel]), 32'(er));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rsp", 32'(rq_w[sel]), 32'h1);
      chk("valid_after_rsp", 32'(rv_w[sel]), 32'h0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] rd;
      logic        er;
      int          n;
      int          k;
      bit          we;
      logic [15:0] addr;

      sel = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_req_ready", 32'(rq_w[0]), 32'h1);
      chk("reset_rsp_valid", 32'(rv_w[0]), 32'h0);
      chk("reset_rsp_rdata", rd_w[0], 32'h0);
      chk("reset_rsp_err", 32'(er_w[0]), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed sequence on the WAIT_CYCLES=1 instance.
      txn(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rd, er);
      chk("store_rdata", rd, 32'h0);
      chk("store_err", 32'(er), 32'h0);
      txn(0, 16'h0010, 32'h0, 4'h0, 0, rd, er);
      chk("load_deadbeef", rd, 32'hDEADBEEF);
      chk("load_err", 32'(er), 32'h0);

      txn(1, 16'h0020, 32'h11223344, 4'hF, 0, rd, er);
      txn(1, 16'h0020, 32'hAABBCCDD, 4'b0101, 1, rd, er);
      txn(0, 16'h0020, 32'h0, 4'h0, 0, rd, er);
      chk("byte_enable_merge", rd, 32'h11BB33DD);

      txn(1, 16'h0000, 32'hCAFEF00D, 4'hF, 0, rd, er);
      txn(0, 16'h0013, 32'h0, 4'hF, 0, rd, er);
      chk("misaligned_err", 32'(er), 32'h1);
      chk("misaligned_rdata", rd, 32'h0);
      txn(1, 16'h1000, 32'h55555555, 4'hF, 0, rd, er);
      chk("out_of_range_err", 32'(er), 32'h1);
      txn(0, 16'h0000, 32'h0, 4'h0, 0, rd, er);
      chk("word0_unchanged", rd, 32'hCAFEF00D);
      txn(1, 16'h0010, 32'h01234567, 4'h0, 0, rd, er);
      chk("be_zero_err", 32'(er), 32'h0);
      txn(0, 16'h0010, 32'h0, 4'h0, 0, rd, er);
      chk("be_zero_noop", rd, 32'hDEADBEEF);

      // Backpressure with a second request waiting.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_addr = 16'h0020;
      n = 0;
      while (!rv_w[sel] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid", 32'(rv_w[sel]), 32'h1);
      chk("bp_rdata", rd_w[sel], 32'hDEADBEEF);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(rv_w[sel]), 32'h1);
         chk("bp_hold_rdata", rd_w[sel], 32'hDEADBEEF);
         chk("bp_hold_ready", 32'(rq_w[sel]), 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_after_handshake", 32'(rq_w[sel]), 32'h1);
      chk("bp_valid_after_handshake", 32'(rv_w[sel]), 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_second_accepted", 32'(rq_w[sel]), 32'h0);
      n = 0;
      while (!rv_w[sel] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_second_rdata", rd_w[sel], 32'h11BB33DD);
      @(posedge clk); #1;

      // Reset while waiting: the store stays, the response is dropped.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040;
      req_wdata = 32'h12345678; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("midwait_valid", 32'(rv_w[sel]), 32'h0);
      chk("midwait_ready", 32'(rq_w[sel]), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_valid_now", 32'(rv_w[sel]), 32'h0);
      chk("rst_ready_now", 32'(rq_w[sel]), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(0, 16'h0040, 32'h0, 4'h0, 0, rd, er);
      chk("store_survives_reset", rd, 32'h12345678);

      // Randomized traffic on every latency variant.
      for (int s = 0; s < NINST; s++) begin
         sel = s;
         for (int w = 0; w < 16; w++) begin
            txn(1, 16'(w * 4), $urandom, 4'hF, 0, rd, er);
         end
         for (int t = 0; t < 40; t++) begin
            k  = $urandom_range(0, 9);
            we = 1'($urandom);
            if (k == 0) addr = 16'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (k == 1) addr = 16'($urandom_range(1024, 16383) * 4);
            else addr = 16'($urandom_range(0, 15) * 4);
            txn(we, addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_mem_resp.md
# riscv_mem_resp

Memory responder for the RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake. It services the request against an internal byte-enabled word RAM, inserts a fixed, configurable number of wait states, and returns read data or an error over a second valid/ready handshake. It sits between `riscv_top`'s data-bus initiator and on-chip storage, and doubles as the bench-side memory model.

## Interface
- `ADDR_W`, default 16: byte-address width, matching the core's address bus.
- `DEPTH_WORDS`, default 1024: number of 32-bit words implemented. Power of two, ≤ 2^(ADDR_W-2).
- `WAIT_CYCLES`, default 1: wait states between request acceptance and response, legal range 0..15.
- `CLK` in 1: single clock. All state updates on its rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `REQ_VALID` in 1: request present.
- `REQ_READY` out 1: responder can accept a request.
- `REQ_WE` in 1: 1 = store, 0 = load.
- `REQ_ADDR` in ADDR_W: byte address.
- `REQ_WDATA` in 32: store data.
- `REQ_BE` in 4: byte enables. Bit i enables `WDATA[8i+7:8i]`.
- `RSP_VALID` out 1: response present.
- `RSP_READY` in 1: initiator accepts response.
- `RSP_RDATA` out 32: load data; 0 for stores and errors.
- `RSP_ERR` out 1: request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `REQ_READY`=1.
  - Acceptance happens on an edge with `REQ_VALID`=1. Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
  - The wait counter loads `WAIT_CYCLES`.
- WAIT:
  - `REQ_READY`=0.
  - The counter decrements each edge. When the counter equals 1 at an edge, the next state is RESP.
- RESP:
  - `RSP_VALID`=1.
  - `RSP_RDATA`/`RSP_ERR` are held stable until an edge with `RSP_READY`=1, then the next state is IDLE.
- Error check, evaluated at acceptance: ERR=1 if `REQ_ADDR[1:0]`≠0 or `REQ_ADDR[ADDR_W-1:2]` ≥ `DEPTH_WORDS`.
  - An erroring request causes no RAM access.
  - `RSP_RDATA`=0 for an erroring request.
- Store, not erroring: bytes with BE=1 are written on the acceptance edge. BE=0000 is a legal no-op with ERR=0.
- Load, not erroring: the full word is read on the acceptance edge and captured into the response register. `REQ_BE` is ignored for loads.
- A store followed by a load to the same word returns the updated data.
- Request inputs are don't-care outside acceptance and are not registered beyond the acceptance edge.
- RAM contents are not reset and are undefined until written.
- Reset (`RST`=0), asynchronous, forces:
  - state IDLE;
  - counter 0;
  - `RSP_VALID`=0, `RSP_RDATA`=0, `RSP_ERR`=0;
  - `REQ_READY`=1 (a decode of state IDLE).
- Reset mid-transaction drops the pending response. A store already committed at acceptance stays in RAM.

## Timing
- Acceptance at edge E. `RSP_VALID` rises after edge E+`WAIT_CYCLES` (with `WAIT_CYCLES`=0, in the cycle after E).
- Response consumed at edge F. `REQ_READY` is 1 in the cycle after F. No request is accepted in the same cycle as a response handshake.
- Maximum throughput: one transaction per `WAIT_CYCLES`+2 cycles when `RSP_READY` is held at 1.
- `RSP_READY` held low stalls indefinitely in RESP with outputs unchanged. There is no timeout.
- All outputs are registered or direct state decodes. No combinational input-to-output paths.

## Structure
- Package `riscv_mem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the word-width constant (32);
  - the byte-enable width (4);
  - the `WAIT_CYCLES` legality check function.
- Sub-module `riscv_mem_array`:
  - synchronous-write, synchronous-read RAM of `DEPTH_WORDS`×32;
  - per-byte write enables;
  - one read/write port.
- Top-level holds the FSM, wait counter, error decode and response register.

## Test plan
- Reset release, `WAIT_CYCLES`=1: store 0xDEADBEEF to 0x0010 with BE=1111 (`RSP_READY`=1) -> `RSP_VALID` 1 cycle after acceptance, ERR=0, RDATA=0. Then load 0x0010 -> RDATA=0xDEADBEEF, ERR=0.
- Byte enables: store 0x11223344 to 0x0020 with BE=1111, then store 0xAABBCCDD with BE=0101 -> load returns 0x11BB33DD.
- Errors: load 0x0013 -> ERR=1, RDATA=0. Store to 0x1000 (word 1024, `DEPTH_WORDS`=1024) -> ERR=1. A subsequent load of word 0 is unchanged.
- Latency sweep over `WAIT_CYCLES`=0, 3, 15 -> `RSP_VALID` rises exactly `WAIT_CYCLES` edges after acceptance, and `REQ_READY`=0 throughout.
- Backpressure: hold `RSP_READY`=0 for 10 cycles during a load -> `RSP_VALID`/`RSP_RDATA` stable. A concurrent `REQ_VALID` is not accepted until the cycle after the response handshake.
- Reset mid-WAIT: store to 0x0040 accepted, `RST` pulsed low in WAIT -> `RSP_VALID`=0 immediately and `REQ_READY`=1. A later load of 0x0040 returns the stored data.
